// File: rtl/clk_frac_div.sv
// rtl/clk_frac_div.sv - multi-channel Bresenham fractional clock-enable and toggle-clock generator
module clk_frac_div #(
    parameter int          CHANNELS = 4,
    parameter int          W        = 16,
    parameter int unsigned DEF_NUM  = 1,
    parameter int unsigned DEF_DEN  = 4
) (
    input  logic                hclkin,
    input  logic                resetn,
    input  logic [CHANNELS-1:0] ch_en,
    input  logic                sync_restart,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [2:0]          cfg_ch,
    input  logic [W-1:0]        cfg_num,
    input  logic [W-1:0]        cfg_den,
    output logic                cfg_err,
    output logic [CHANNELS-1:0] strobe,
    output logic [CHANNELS-1:0] clkout
);

    // per-channel rate state
    logic [W-1:0]          acc_q [CHANNELS];
    logic [W-1:0]          acc_d [CHANNELS];
    logic [W-1:0]          num_q [CHANNELS];
    logic [W-1:0]          num_d [CHANNELS];
    logic [W-1:0]          den_q [CHANNELS];
    logic [W-1:0]          den_d [CHANNELS];
    logic [CHANNELS-1:0]   strobe_q, strobe_d;
    logic [CHANNELS-1:0]   clkout_q, clkout_d;

    // single-entry pending configuration slot
    logic                  pend_q, pend_d;
    logic [2:0]            pend_ch_q, pend_ch_d;
    logic [W-1:0]          pend_num_q, pend_num_d;
    logic [W-1:0]          pend_den_q, pend_den_d;
    logic                  cfg_err_q, cfg_err_d;

    // sum is one bit wider so acc+num cannot wrap before the compare with den
    logic [W:0]            sum [CHANNELS];
    logic [CHANNELS-1:0]   hit;
    logic [CHANNELS-1:0]   apply;
    logic                  accept;
    logic                  cfg_bad;

    assign cfg_ready = ~pend_q;
    assign cfg_err   = cfg_err_q;
    assign strobe    = strobe_q;
    assign clkout    = clkout_q;

    // accumulator step per channel; a pending config lands only at a phase-safe edge
    always_comb begin
        acc_d    = acc_q;
        num_d    = num_q;
        den_d    = den_q;
        strobe_d = strobe_q;
        clkout_d = clkout_q;
        for (int c = 0; c < CHANNELS; c++) begin
            sum[c] = {1'b0, acc_q[c]} + {1'b0, num_q[c]};
            hit[c] = (sum[c] >= {1'b0, den_q[c]});
            if (sync_restart) begin
                acc_d[c]    = '0;
                strobe_d[c] = 1'b0;
                clkout_d[c] = 1'b0;
            end else if (!ch_en[c]) begin
                strobe_d[c] = 1'b0;
            end else if (hit[c]) begin
                acc_d[c]    = W'(sum[c] - {1'b0, den_q[c]});
                strobe_d[c] = 1'b1;
                clkout_d[c] = ~clkout_q[c];
            end else begin
                acc_d[c]    = sum[c][W-1:0];
                strobe_d[c] = 1'b0;
            end
            // the outputs of this edge keep the old rate; only acc/num/den switch over
            apply[c] = pend_q && (pend_ch_q == 3'(c)) &&
                       (sync_restart || !ch_en[c] || (num_q[c] == '0) || hit[c]);
            if (apply[c]) begin
                num_d[c] = pend_num_q;
                den_d[c] = pend_den_q;
                acc_d[c] = '0;
            end
        end
    end

    // config request validation and pending-slot bookkeeping
    always_comb begin
        accept     = cfg_valid && !pend_q;
        cfg_bad    = (cfg_den == '0) || (cfg_num > cfg_den) ||
                     ({1'b0, cfg_ch} >= 4'(CHANNELS));
        pend_d     = pend_q;
        pend_ch_d  = pend_ch_q;
        pend_num_d = pend_num_q;
        pend_den_d = pend_den_q;
        cfg_err_d  = accept && cfg_bad;
        if (|apply) begin
            pend_d = 1'b0;
        end
        if (accept && !cfg_bad) begin
            pend_d     = 1'b1;
            pend_ch_d  = cfg_ch;
            pend_num_d = cfg_num;
            pend_den_d = cfg_den;
        end
    end

    // state registers; reset discards any pending config and restores default rates
    always_ff @(posedge hclkin or negedge resetn) begin
        if (!resetn) begin
            for (int c = 0; c < CHANNELS; c++) begin
                acc_q[c] <= '0;
                num_q[c] <= W'(DEF_NUM);
                den_q[c] <= W'(DEF_DEN);
            end
            strobe_q   <= '0;
            clkout_q   <= '0;
            pend_q     <= 1'b0;
            pend_ch_q  <= '0;
            pend_num_q <= '0;
            pend_den_q <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            num_q      <= num_d;
            den_q      <= den_d;
            strobe_q   <= strobe_d;
            clkout_q   <= clkout_d;
            pend_q     <= pend_d;
            pend_ch_q  <= pend_ch_d;
            pend_num_q <= pend_num_d;
            pend_den_q <= pend_den_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

endmodule

// File: tb/tb_clk_frac_div.sv
// tb/tb_clk_frac_div.sv - self-checking bench for clk_frac_div
module tb_clk_frac_div;
    localparam int CH = 4;
    localparam int W  = 16;

    logic          hclkin = 1'b0;
    logic          resetn;
    logic [CH-1:0] ch_en;
    logic          sync_restart;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [2:0]    cfg_ch;
    logic [W-1:0]  cfg_num;
    logic [W-1:0]  cfg_den;
    logic          cfg_err;
    logic [CH-1:0] strobe;
    logic [CH-1:0] clkout;

    int n_tests = 0;
    int n_fail  = 0;

    clk_frac_div #(.CHANNELS(CH), .W(W), .DEF_NUM(1), .DEF_DEN(4)) dut (
        .hclkin(hclkin), .resetn(resetn), .ch_en(ch_en), .sync_restart(sync_restart),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_num(cfg_num), .cfg_den(cfg_den), .cfg_err(cfg_err),
        .strobe(strobe), .clkout(clkout)
    );

    always #5 hclkin = ~hclkin;

    // reference model: strobe k (k-th enabled edge since phase zero) fires when
    // floor(k*num/den) increases; clkout is the parity of strobes since phase reset
    longint unsigned m_k   [CH];
    longint unsigned m_num [CH];
    longint unsigned m_den [CH];
    bit [CH-1:0]     m_strobe, m_clk;
    bit              m_pend, m_err;
    int              m_pch;
    longint unsigned m_pnum, m_pden;

    function automatic void model_reset();
        for (int c = 0; c < CH; c++) begin
            m_k[c] = 0; m_num[c] = 1; m_den[c] = 4;
        end
        m_strobe = '0; m_clk = '0; m_pend = 0; m_err = 0;
    endfunction

    function automatic void model_step();
        bit              was_pend;
        bit              s;
        bit              bad;
        longint unsigned k1;
        was_pend = m_pend;
        for (int c = 0; c < CH; c++) begin
            s = 0;
            if (sync_restart) begin
                m_k[c] = 0;
                m_clk[c] = 0;
            end else if (ch_en[c]) begin
                k1 = m_k[c] + 1;
                s = ((k1 * m_num[c]) / m_den[c]) != (((k1 - 1) * m_num[c]) / m_den[c]);
                m_k[c] = k1 % m_den[c];
                if (s) m_clk[c] = ~m_clk[c];
            end
            m_strobe[c] = s;
            if (was_pend && m_pch == c && (sync_restart || !ch_en[c] || m_num[c] == 0 || s)) begin
                m_num[c] = m_pnum;
                m_den[c] = m_pden;
                m_k[c] = 0;
                m_pend = 0;
            end
        end
        bad = (cfg_den == 0) || (cfg_num > cfg_den) || (int'(cfg_ch) >= CH);
        m_err = cfg_valid && !was_pend && bad;
        if (cfg_valid && !was_pend && !bad) begin
            m_pend = 1;
            m_pch  = int'(cfg_ch);
            m_pnum = longint'(cfg_num);
            m_pden = longint'(cfg_den);
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        check("model_strobe", 32'(strobe), 32'(m_strobe));
        check("model_clkout", 32'(clkout), 32'(m_clk));
        check("model_cfg_err", 32'(cfg_err), 32'(m_err));
        check("model_cfg_ready", 32'(cfg_ready), 32'(!m_pend));
    endtask

    task automatic tick();
        @(posedge hclkin);
        model_step();
        #1;
    endtask

    task automatic step();
        tick();
        check_all();
    endtask

    task automatic idle_inputs();
        ch_en = '1; sync_restart = 0; cfg_valid = 0; cfg_ch = 0; cfg_num = 0; cfg_den = 0;
    endtask

    task automatic do_reset();
        resetn = 0;
        idle_inputs();
        #12;
        model_reset();
        check("reset_strobe", 32'(strobe), 32'(0));
        check("reset_clkout", 32'(clkout), 32'(0));
        check("reset_ready", 32'(cfg_ready), 32'(1));
        check("reset_err", 32'(cfg_err), 32'(0));
        @(negedge hclkin);
        resetn = 1;
    endtask

    typedef struct {
        logic [CH-1:0] en;
        logic          vld;
        logic [2:0]    ch;
        logic [W-1:0]  num;
        logic [W-1:0]  den;
        logic [CH-1:0] exp_stb;
        logic [CH-1:0] exp_clk;
        logic          exp_err;
        logic          exp_rdy;
    } vec_t;

    vec_t tbl[12];
    bit   pat7[7];
    bit   pat2[2];
    int   cnt;
    int   waited;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // edges 1..8: default 1/4 rate; edges 9..11: three rejected writes; edge 12: strobe
        tbl[0]  = '{4'hF, 0, 3'd0, 16'd0, 16'd0, 4'h0, 4'h0, 0, 1};
        tbl[1]  = '{4'hF, 0, 3'd0, 16'd0, 16'd0, 4'h0, 4'h0, 0, 1};
        tbl[2]  = '{4'hF, 0, 3'd0, 16'd0, 16'd0, 4'h0, 4'h0, 0, 1};
        tbl[3]  = '{4'hF, 0, 3'd0, 16'd0, 16'd0, 4'hF, 4'hF, 0, 1};
        tbl[4]  = '{4'hF, 0, 3'd0, 16'd0, 16'd0, 4'h0, 4'hF, 0, 1};
        tbl[5]  = '{4'hF, 0, 3'd0, 16'd0, 16'd0, 4'h0, 4'hF, 0, 1};
        tbl[6]  = '{4'hF, 0, 3'd0, 16'd0, 16'd0, 4'h0, 4'hF, 0, 1};
        tbl[7]  = '{4'hF, 0, 3'd0, 16'd0, 16'd0, 4'hF, 4'h0, 0, 1};
        tbl[8]  = '{4'hF, 1, 3'd1, 16'd1, 16'd0, 4'h0, 4'h0, 1, 1};
        tbl[9]  = '{4'hF, 1, 3'd0, 16'd5, 16'd4, 4'h0, 4'h0, 1, 1};
        tbl[10] = '{4'hF, 1, 3'd5, 16'd1, 16'd4, 4'h0, 4'h0, 1, 1};
        tbl[11] = '{4'hF, 0, 3'd0, 16'd0, 16'd0, 4'hF, 4'hF, 0, 1};
        pat7 = '{0, 0, 1, 0, 1, 0, 1};
        pat2 = '{0, 1};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            ch_en = tbl[i].en; cfg_valid = tbl[i].vld; cfg_ch = tbl[i].ch;
            cfg_num = tbl[i].num; cfg_den = tbl[i].den;
            tick();
            check($sformatf("tbl%0d_strobe", i), 32'(strobe), 32'(tbl[i].exp_stb));
            check($sformatf("tbl%0d_clkout", i), 32'(clkout), 32'(tbl[i].exp_clk));
            check($sformatf("tbl%0d_err", i), 32'(cfg_err), 32'(tbl[i].exp_err));
            check($sformatf("tbl%0d_ready", i), 32'(cfg_ready), 32'(tbl[i].exp_rdy));
        end
        idle_inputs();

        // ch1 -> 3/7: pending until ch1's next strobe at edge 16
        cfg_valid = 1; cfg_ch = 1; cfg_num = 3; cfg_den = 7;
        step();
        cfg_valid = 0;
        check("ch1_ready_low", 32'(cfg_ready), 32'(0));
        step();
        step();
        check("ch1_ready_still_low", 32'(cfg_ready), 32'(0));
        step();
        check("ch1_apply_strobe", 32'(strobe[1]), 32'(1));
        check("ch1_ready_back", 32'(cfg_ready), 32'(1));
        cnt = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            check("ch1_pattern", 32'(strobe[1]), 32'(pat7[i % 7]));
            cnt += int'(strobe[1]);
        end
        check("ch1_strobe_count", 32'(cnt), 32'(6));

        // ch2 -> num=0 (waits for ch2 strobe), then 1/2 applies on the very next edge
        cfg_valid = 1; cfg_ch = 2; cfg_num = 0; cfg_den = 4;
        step();
        cfg_valid = 0;
        waited = 0;
        while (!cfg_ready && waited < 20) begin
            step();
            waited++;
        end
        check("ch2_num0_applied", 32'(cfg_ready), 32'(1));
        cfg_valid = 1; cfg_ch = 2; cfg_num = 1; cfg_den = 2;
        step();
        cfg_valid = 0;
        check("ch2_half_pending", 32'(cfg_ready), 32'(0));
        step();
        check("ch2_half_applied", 32'(cfg_ready), 32'(1));
        for (int i = 0; i < 6; i++) begin
            step();
            check("ch2_half_pattern", 32'(strobe[2]), 32'(pat2[i % 2]));
        end

        // scatter phases, then realign with sync_restart
        ch_en = 4'b0101;
        for (int i = 0; i < 3; i++) step();
        ch_en = '1; sync_restart = 1;
        step();
        sync_restart = 0;
        check("sync_clkout", 32'(clkout), 32'(0));
        check("sync_strobe", 32'(strobe), 32'(0));
        for (int i = 0; i < 3; i++) begin
            step();
            check("sync_quiet", 32'({strobe[3], strobe[0]}), 32'(0));
        end
        step();
        check("sync_coincide", 32'({strobe[3], strobe[0]}), 32'(3));

        // reset with a pending config: outputs drop at once, config is discarded
        cfg_valid = 1; cfg_ch = 0; cfg_num = 1; cfg_den = 3;
        step();
        cfg_valid = 0;
        check("rst_pending", 32'(cfg_ready), 32'(0));
        #2;
        resetn = 0;
        #1;
        check("rst_async_strobe", 32'(strobe), 32'(0));
        check("rst_async_clkout", 32'(clkout), 32'(0));
        check("rst_async_ready", 32'(cfg_ready), 32'(1));
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            step();
            check("rst_default_rate", 32'(strobe[0]), 32'(i == 4));
        end

        // randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            ch_en = ($urandom_range(0, 9) == 0) ? CH'($urandom) : '1;
            sync_restart = ($urandom_range(0, 40) == 0);
            cfg_valid = ($urandom_range(0, 5) == 0);
            cfg_ch = 3'($urandom_range(0, 4));
            if ($urandom_range(0, 7) == 0) begin
                cfg_den = W'($urandom_range(1, 65535));
                cfg_num = W'($urandom_range(0, int'(cfg_den)));
            end else begin
                cfg_den = W'($urandom_range(0, 10));
                cfg_num = W'($urandom_range(0, int'(cfg_den) + 1));
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/clk_frac_div.md
Name: clk_frac_div

Overview:
- Parametrised successor to the fixed divide-by-4 clock divider.
- Generates CHANNELS independent fractional-rate clock-enable strobes, plus toggle clocks, from one source clock, using a Bresenham NUM/DEN accumulator per channel.
- Rates are reconfigurable at run time through a valid/ready config port; updates are applied glitch-free at a strobe boundary.
- Feeds GBA timer, audio-sample and peripheral tick logic; replaces per-rate hard divider instances.

Parameters:
- CHANNELS, 4, number of independent divider channels (1..8).
- W, 16, width of NUM and DEN.
- DEF_NUM, 1, reset NUM for every channel.
- DEF_DEN, 4, reset DEN for every channel; default rate is hclkin/4.

Ports:
- hclkin  in  1  source clock; all logic is on its rising edge.
- resetn  in  1  asynchronous active-low reset.
- ch_en  in  CHANNELS  per-channel run enable.
- sync_restart  in  1  single-cycle pulse; phase-aligns all channels.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config slot free.
- cfg_ch  in  3  target channel index.
- cfg_num  in  W  numerator (rate = f_hclkin*NUM/DEN).
- cfg_den  in  W  denominator.
- cfg_err  out  1  one-cycle pulse: request rejected.
- strobe  out  CHANNELS  one-cycle tick per division period.
- clkout  out  CHANNELS  toggles on every strobe, giving rate/2 at about 50% duty.

Behaviour:
- Reset (resetn low, asynchronous):
  - all acc=0, num=DEF_NUM, den=DEF_DEN.
  - strobe=0, clkout=0, cfg_ready=1, cfg_err=0, pending cleared.
- Per channel, at each edge, in priority order:
  1. sync_restart: acc<=0, strobe<=0, clkout<=0 for all channels.
  2. ch_en low: acc and clkout hold, strobe<=0.
  3. Otherwise: sum = acc+num, computed W+1 bits wide.
     - If sum>=den: acc<=sum-den, strobe<=1, clkout<=~clkout.
     - Else: acc<=sum, strobe<=0.
- Latency: strobe is registered. With 1/4 and ch_en high from edge 0, strobe is high after edges 4, 8, 12, ...
- num==0: channel never strobes.
- num==den: strobe is high continuously while enabled; clkout toggles every cycle.
- Config handshake:
  - A request is accepted when cfg_valid && cfg_ready.
  - It is rejected if cfg_den==0, cfg_num>cfg_den, or cfg_ch>=CHANNELS. On rejection: cfg_err=1 the next cycle, no state change, cfg_ready stays 1.
  - A valid request is stored in the single pending slot, and cfg_ready<=0 the next cycle.
- Applying a pending config to channel c, on the first edge where any of the following holds:
  - channel c produces a strobe (its sum>=den);
  - ch_en[c]==0;
  - the current num[c]==0;
  - sync_restart is high.
- On the apply edge:
  - num/den load; acc<=0.
  - The strobe/clkout update of that edge still occurs under the old values.
  - pending clears; cfg_ready<=1 the next cycle.
- Only the targeted channel is affected; the other channels continue cycle-exact.
- cfg_valid while cfg_ready=0: ignored, with no error. The requester must hold cfg_valid until it sees ready.
- Reset mid-operation: all state returns to reset values immediately; a pending config is discarded.
- Arithmetic never overflows: acc<den<=2^W-1 and num<=den, so sum<2^(W+1).

Test Plan:
- Reset, ch_en=all 1 -> each strobe high after edges 4, 8, 12; clkout rises at edge 4 and falls at edge 8.
- Write ch1 num=3 den=7 (cfg_valid one cycle, ready=1) -> cfg_ready low until ch1's next strobe. Afterwards there are exactly 3 strobes per 7 cycles in the pattern acc 3,6,2,5,1,4,0. Channels 0, 2, 3 are unchanged.
- Write den=0, then num=5 den=4, then cfg_ch=5 (CHANNELS=4) -> three cfg_err pulses; all rates unchanged; cfg_ready remains 1.
- Write ch2 num=0; then write ch2 num=1 den=2 -> the second write applies on the next edge (num==0 rule); strobe every 2nd cycle.
- Let channels run at different phases, then pulse sync_restart -> all acc=0 and clkout=0. With default 1/4, all strobes coincide 4 edges later.
- Deassert resetn mid-period with a config pending -> outputs 0 immediately. After release: defaults restored, cfg_ready=1, the pending config is not applied.
